// File: rtl/ad7946_decimator_pkg.sv
// Shared types and field layout for the AD7946 boxcar decimator.
// The output word packs channel, frame count and sum into 32 bits.
package ad7946_pkg;

  localparam int SAMPLE_W = 14;
  localparam int SUM_W    = 22;
  localparam int FRM_W    = 7;
  localparam int CNT_W    = 8;
  localparam int DATA_W   = 32;

  // Field positions inside m_data.
  localparam int CHAN_BIT = 31;
  localparam int FRM_MSB  = 30;
  localparam int FRM_LSB  = 24;
  localparam int PAD_MSB  = 23;
  localparam int PAD_LSB  = 22;
  localparam int SUM_MSB  = 21;
  localparam int SUM_LSB  = 0;

  typedef struct packed {
    logic             chan;
    logic [FRM_W-1:0] frm;
    logic [1:0]       pad;
    logic [SUM_W-1:0] sum;
  } dec_word_t;

  function automatic dec_word_t make_word(input logic             chan,
                                          input logic [FRM_W-1:0] frm,
                                          input logic [SUM_W-1:0] sum);
    return '{chan: chan, frm: frm, pad: 2'b00, sum: sum};
  endfunction

endpackage

// File: rtl/ad7946_decimator_if.sv
// Ready/valid stream carrying decimated result words to the consumer.
interface ad7946_decimator_if;
  import ad7946_pkg::*;

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);

endinterface

// File: rtl/ad7946_decimator_fifo.sv
// First-word-fall-through synchronous FIFO; a pop frees a slot for a
// same-cycle push even when full.
module sync_fifo_fwft #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign level   = count;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // NOTE: storage is not reset; rdata is masked while empty, so stale contents never leave.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ad7946_decimator.sv
// Per-channel boxcar decimator for AD7946 samples: sums 2^LOG2_DECIM samples,
// tags each sum with channel and frame count, and queues it in an FWFT FIFO.
module ad7946_decimator
  import ad7946_pkg::*;
#(
  parameter int LOG2_DECIM = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         enable,
  input  logic                         ch0_dv,
  input  logic                         ch1_dv,
  input  logic [SAMPLE_W-1:0]          din,
  ad7946_decimator_if.master           m_axis,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         ovf,
  output logic                         proto_err,
  input  logic                         clear_err
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_DECIM) - 1);

  logic [SUM_W-1:0]  acc [2];
  logic [CNT_W-1:0]  cnt [2];
  logic [FRM_W-1:0]  frm [2];

  dec_word_t         res_word;
  logic              res_valid;

  logic              strobe;
  logic              sel;
  logic              last;
  logic [SUM_W-1:0]  acc_next;
  logic              proto_set;
  logic              pop;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    strobe    = 1'b0;
    sel       = 1'b0;
    proto_set = 1'b0;
    strobe    = enable && (ch0_dv || ch1_dv);
    // Channel 0 wins when both strobes collide.
    sel       = !ch0_dv;
    proto_set = enable && ch0_dv && ch1_dv;
    acc_next  = acc[sel] + SUM_W'(din);
    last      = (cnt[sel] == LAST_CNT);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int c = 0; c < 2; c++) begin
        acc[c] <= '0;
        cnt[c] <= '0;
        frm[c] <= '0;
      end
      res_valid <= 1'b0;
      res_word  <= '0;
    end else begin
      res_valid <= 1'b0;
      if (!enable) begin
        // Disabling discards any partial sum and restarts frame numbering.
        for (int c = 0; c < 2; c++) begin
          acc[c] <= '0;
          cnt[c] <= '0;
          frm[c] <= '0;
        end
      end else if (strobe) begin
        if (last) begin
          res_valid <= 1'b1;
          res_word  <= make_word(sel, frm[sel], acc_next);
          acc[sel]  <= '0;
          cnt[sel]  <= '0;
          frm[sel]  <= frm[sel] + FRM_W'(1);
        end else begin
          acc[sel]  <= acc_next;
          cnt[sel]  <= cnt[sel] + CNT_W'(1);
        end
      end
    end
  end

  assign pop  = m_axis.m_valid && m_axis.m_ready;
  // A same-cycle pop makes room, so only a push into a full, stalled FIFO is lost.
  assign drop = res_valid && fifo_full && !pop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovf       <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      ovf       <= drop      || (ovf       && !clear_err);
      proto_err <= proto_set || (proto_err && !clear_err);
    end
  end

  sync_fifo_fwft #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (res_valid),
    .wdata  (res_word),
    .pop    (pop),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  assign m_axis.m_valid = !fifo_empty;
  assign m_axis.m_data  = fifo_rdata;

endmodule

// File: tb/tb_ad7946_decimator.sv
// Scoreboard bench: two decimator instances (N=4 / depth 4 and N=256 / depth 16)
// share stimulus; a sample-counting reference model predicts every output word.
module tb_ad7946_decimator;
  import ad7946_pkg::*;

  localparam int L2_A = 2, DEPTH_A = 4;
  localparam int L2_B = 8, DEPTH_B = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic        ch0_dv = 1'b0;
  logic        ch1_dv = 1'b0;
  logic        clear_err = 1'b0;
  logic        ready = 1'b0;
  logic [13:0] din = '0;
  bit          rand_ready = 1'b0;

  logic [2:0]  lvl_a;
  logic [4:0]  lvl_b;
  logic        ovf_a, ovf_b, perr_a, perr_b;

  ad7946_decimator_if if_a ();
  ad7946_decimator_if if_b ();
  assign if_a.m_ready = ready;
  assign if_b.m_ready = ready;

  ad7946_decimator #(.LOG2_DECIM(L2_A), .FIFO_DEPTH(DEPTH_A)) dut_a (
    .clk(clk), .resetn(resetn), .enable(enable), .ch0_dv(ch0_dv), .ch1_dv(ch1_dv),
    .din(din), .m_axis(if_a), .fifo_level(lvl_a), .ovf(ovf_a), .proto_err(perr_a),
    .clear_err(clear_err));

  ad7946_decimator #(.LOG2_DECIM(L2_B), .FIFO_DEPTH(DEPTH_B)) dut_b (
    .clk(clk), .resetn(resetn), .enable(enable), .ch0_dv(ch0_dv), .ch1_dv(ch1_dv),
    .din(din), .m_axis(if_b), .fifo_level(lvl_b), .ovf(ovf_b), .proto_err(perr_b),
    .clear_err(clear_err));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain running sums and sample counts per instance and channel.
  int unsigned m_acc [2][2];
  int          m_cnt [2][2];
  int          m_frm [2][2];
  int          n_of  [2];
  logic [31:0] q_a [$];
  logic [31:0] q_b [$];
  logic [31:0] last_word [2][2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 2; c++) begin
        m_acc[k][c] = 0;
        m_cnt[k][c] = 0;
        m_frm[k][c] = 0;
      end
    q_a.delete();
    q_b.delete();
  endtask

  task automatic model_step(input bit s0, input bit s1, input int unsigned d);
    int c;
    logic [31:0] w;
    if (!enable) begin
      for (int k = 0; k < 2; k++)
        for (int cc = 0; cc < 2; cc++) begin
          m_acc[k][cc] = 0;
          m_cnt[k][cc] = 0;
          m_frm[k][cc] = 0;
        end
      return;
    end
    if (!(s0 || s1)) return;
    c = s0 ? 0 : 1;
    for (int k = 0; k < 2; k++) begin
      m_acc[k][c] += d;
      m_cnt[k][c] += 1;
      if (m_cnt[k][c] == n_of[k]) begin
        w = (32'(c) << 31) | (32'(m_frm[k][c]) << 24) | 32'(m_acc[k][c]);
        if (k == 0) begin
          if (q_a.size() < DEPTH_A) q_a.push_back(w);
        end else begin
          if (q_b.size() < DEPTH_B) q_b.push_back(w);
        end
        m_acc[k][c] = 0;
        m_cnt[k][c] = 0;
        m_frm[k][c] = (m_frm[k][c] + 1) % 128;
      end
    end
  endtask

  task automatic drive_cycle(input bit s0, input bit s1, input int unsigned d);
    if (rand_ready) ready = ($urandom_range(0, 9) < 7);
    ch0_dv = s0;
    ch1_dv = s1;
    din    = 14'(d);
    model_step(s0, s1, d);
    @(posedge clk);
    #1;
    ch0_dv = 1'b0;
    ch1_dv = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(1'b0, 1'b0, 0);
  endtask

  task automatic frame_ch0(input int n, input int unsigned d);
    repeat (n) begin
      drive_cycle(1'b1, 1'b0, d);
      idle(1);
    end
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && t < budget) begin
      idle(1);
      t++;
    end
    check("drain_timeout", 32'(q_a.size() + q_b.size()), 0);
    idle(3);
    check("no_extra_word_a", if_a.m_valid, 1'b0);
  endtask

  // Monitor: compare each accepted word against the scoreboard and check stall stability.
  bit          stalled   [2];
  logic [31:0] stall_dat [2];

  task automatic mon_one(input int k, input logic v, input logic [31:0] d);
    logic [31:0] e;
    if (stalled[k]) begin
      check(k == 0 ? "hold_valid_a" : "hold_valid_b", v, 1'b1);
      check(k == 0 ? "hold_data_a"  : "hold_data_b",  d, stall_dat[k]);
    end
    if (v && ready) begin
      if ((k == 0 && q_a.size() == 0) || (k == 1 && q_b.size() == 0)) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word dut%0d: got 0x%08h, expected no word", k, d);
      end else begin
        if (k == 0) e = q_a.pop_front();
        else        e = q_b.pop_front();
        check(k == 0 ? "word_a" : "word_b", d, e);
        last_word[k][d[31]] = d;
      end
    end
    stalled[k]   = v && !ready;
    stall_dat[k] = d;
  endtask

  always @(negedge clk) begin
    if (!resetn) begin
      stalled[0] = 1'b0;
      stalled[1] = 1'b0;
    end else begin
      mon_one(0, if_a.m_valid, if_a.m_data);
      mon_one(1, if_b.m_valid, if_b.m_data);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int pick;
    n_of[0] = 1 << L2_A;
    n_of[1] = 1 << L2_B;
    model_reset();

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", if_a.m_valid, 1'b0);
    check("rst_data",  if_a.m_data, 32'h0);
    check("rst_level", lvl_a, 3'd0);
    check("rst_flags", {ovf_a, perr_a, ovf_b, perr_b}, 4'b0);
    #2 resetn = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b1;
    ready  = 1'b1;

    // Basic frame and two-cycle latency.
    drive_cycle(1'b1, 1'b0, 100); idle(2);
    drive_cycle(1'b1, 1'b0, 200); idle(2);
    drive_cycle(1'b1, 1'b0, 300); idle(2);
    drive_cycle(1'b1, 1'b0, 400);
    @(negedge clk);
    check("lat_edge_k", if_a.m_valid, 1'b0);
    @(negedge clk);
    check("lat_edge_k1", if_a.m_valid, 1'b1);
    @(posedge clk);
    #1;
    idle(3);
    check("t1_word", last_word[0][0], 32'h0000_03E8);
    frame_ch0(4, 1234);
    idle(3);
    check("t1_frm1", last_word[0][0], 32'h0100_1348);

    // Interleaved channels at the upstream cadence.
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, 1'b0, $urandom_range(0, 16383)); idle(75);
      drive_cycle(1'b0, 1'b1, 16383); idle(75);
    end
    idle(3);
    check("t2_ch1_max", last_word[0][1], 32'h8000_FFFC);

    // Full-scale 256-sample frame, strobes every cycle.
    enable = 1'b0; idle(1); enable = 1'b1;
    repeat (256) drive_cycle(1'b1, 1'b0, 16383);
    idle(5);
    check("t2_b_max",   last_word[1][0], 32'h003F_FF00);
    check("t2_a_frm63", last_word[0][0], 32'h3F00_FFFC);

    // Randomized traffic with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      pick = $urandom_range(0, 9);
      if (pick < 5)      drive_cycle(1'b1, 1'b0, $urandom_range(0, 16383));
      else if (pick < 9) drive_cycle(1'b0, 1'b1, $urandom_range(0, 16383));
      else               drive_cycle(1'b0, 1'b0, 0);
      idle($urandom_range(2, 6));
    end
    rand_ready = 1'b0;
    ready = 1'b1;
    wait_drain(200);
    check("rand_flags", {ovf_a, perr_a, ovf_b, perr_b}, 4'b0);

    // Overflow: fill, drop one frame, drain, then clear.
    enable = 1'b0; idle(1); enable = 1'b1;
    ready = 1'b0;
    frame_ch0(16, 3);
    idle(3);
    check("t3_level_full", lvl_a, 3'd4);
    check("t3_no_ovf_yet", ovf_a, 1'b0);
    frame_ch0(4, 3);
    idle(3);
    check("t3_ovf", ovf_a, 1'b1);
    check("t3_level_held", lvl_a, 3'd4);
    ready = 1'b1;
    wait_drain(100);
    frame_ch0(4, 3);
    wait_drain(100);
    check("t3_gap_frm", last_word[0][0], 32'h0500_000C);
    check("t3_ovf_sticky", ovf_a, 1'b1);
    clear_err = 1'b1; idle(1); clear_err = 1'b0;
    idle(1);
    check("t3_ovf_clear", ovf_a, 1'b0);

    // Protocol violation: channel 0 processed, channel 1 ignored.
    drive_cycle(1'b1, 1'b1, 50);
    idle(1);
    check("t4_perr", perr_a, 1'b1);
    clear_err = 1'b1; idle(1); clear_err = 1'b0;
    idle(1);
    check("t4_perr_clear", perr_a, 1'b0);
    clear_err = 1'b1;
    drive_cycle(1'b1, 1'b1, 60);
    clear_err = 1'b0;
    idle(1);
    check("t4_set_wins", perr_a, 1'b1);
    drive_cycle(1'b1, 1'b0, 70); idle(1);
    drive_cycle(1'b1, 1'b0, 80); idle(1);
    repeat (4) begin drive_cycle(1'b0, 1'b1, 5); idle(1); end
    wait_drain(50);
    check("t4_ch0_word", last_word[0][0], 32'h0600_0104);
    check("t4_ch1_word", last_word[0][1], 32'h8000_0014);
    clear_err = 1'b1; idle(1); clear_err = 1'b0;

    // Enable dropped mid-frame discards the partial sum.
    enable = 1'b0; idle(1); enable = 1'b1;
    frame_ch0(2, 999);
    enable = 1'b0; idle(3); enable = 1'b1;
    frame_ch0(4, 10);
    wait_drain(50);
    check("t5_word", last_word[0][0], 32'h0000_0028);

    // Asynchronous reset with a full FIFO and sticky flags set.
    ready = 1'b0;
    frame_ch0(20, 1);
    drive_cycle(1'b1, 1'b1, 1);
    frame_ch0(2, 1);
    idle(3);
    check("t6_pre_flags", {ovf_a, perr_a}, 2'b11);
    check("t6_pre_level", lvl_a, 3'd4);
    #3 resetn = 1'b0;
    model_reset();
    #1;
    check("t6_async_valid", {if_a.m_valid, if_b.m_valid}, 2'b00);
    check("t6_async_level", lvl_a, 3'd0);
    check("t6_async_flags", {ovf_a, perr_a, ovf_b, perr_b}, 4'b0);
    repeat (2) @(posedge clk);
    #3 resetn = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b1;
    drive_cycle(1'b1, 1'b0, 7);  idle(1);
    drive_cycle(1'b1, 1'b0, 8);  idle(1);
    drive_cycle(1'b1, 1'b0, 9);  idle(1);
    drive_cycle(1'b1, 1'b0, 10); idle(1);
    wait_drain(50);
    check("t6_post_word", last_word[0][0], 32'h0000_0022);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ad7946_decimator.md
# ad7946_decimator

Downstream of the AD7946 controller: per-channel boxcar decimator feeding a small output FIFO.
- Consumes the controller's `ch0_dv`/`ch1_dv` strobes and 14-bit `din`.
- Sums 2^LOG2_DECIM consecutive samples per channel and tags each sum with channel and frame count.
- Buffers results for an AXI-stream style reader, so software or DMA sees low-rate, low-noise words instead of ~700 ksps raw samples.

## Interface
Parameters:
- LOG2_DECIM, 4, log2 of samples per sum; legal 0..8.
- FIFO_DEPTH, 16, output FIFO entries; power of two, ≥4.

Ports:
- clk  in  1  100 MHz axi clock.
- resetn  in  1  reset, asynchronous and active-low.
- enable  in  1  accumulation enable.
- ch0_dv  in  1  single-cycle strobe: `din` holds a channel-0 sample.
- ch1_dv  in  1  single-cycle strobe: `din` holds a channel-1 sample.
- din  in  14  unsigned sample.
- m_valid  out  1  FIFO head valid.
- m_ready  in  1  consumer accept.
- m_data  out  32  `[31]` channel, `[30:24]` frame count, `[23:22]` zero, `[21:0]` sum, zero-extended.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy.
- ovf  out  1  sticky: a result was dropped on a full FIFO.
- proto_err  out  1  sticky: `ch0_dv` and `ch1_dv` were high in the same cycle.
- clear_err  in  1  pulse; clears `ovf` and `proto_err`.

## Operation
Per channel c there is an accumulator `acc_c` (22 bit), a sample counter `cnt_c` (8 bit) and a frame counter `frm_c` (7 bit). N = 2^LOG2_DECIM.

On `chc_dv` with `enable` = 1:
- If `cnt_c` = N-1: the result `acc_c + din` is registered with `{c, frm_c}`. Then `acc_c` ← 0, `cnt_c` ← 0, `frm_c` ← `frm_c`+1, wrapping at 127.
- Otherwise: `acc_c` += `din`, `cnt_c` += 1.

Arithmetic and special cases:
- The maximum sum is 16383·256 < 2^22, so no saturation logic is needed.
- LOG2_DECIM = 0: every sample is a result.

Simultaneous strobes:
- Both `ch0_dv` and `ch1_dv` high in one cycle is a protocol violation.
- Channel 0 is processed, the channel-1 strobe is ignored, and `proto_err` is set.

Enable:
- While `enable` = 0: all `acc`, `cnt` and `frm` are held at 0 and strobes are ignored.
- The FIFO keeps draining while `enable` = 0.
- Deasserting `enable` mid-frame discards the partial sum.

FIFO write path:
- A registered result is written to the FIFO on the next edge.
- If the FIFO is full at that edge, the word is dropped and `ovf` is set.
- `frm_c` still advanced, so software sees the gap in frame counts.

Error flags:
- `clear_err` clears both sticky flags.
- If a set condition occurs in the same cycle as `clear_err`, set wins.

FIFO behaviour:
- First-word-fall-through: `m_data` is valid whenever `m_valid` = 1.
- A pop occurs when `m_valid && m_ready`.
- Push and pop in the same cycle on a full FIFO: the pop frees the slot and the push succeeds, with no `ovf`.
- Push and pop in the same cycle on an empty FIFO: not possible, since `m_valid` = 0.
- `fifo_level` updates the cycle after a push or pop.

## Timing
Reset values (asynchronous assert, synchronous deassert assumed upstream):
- `m_valid` = 0, `m_data` = 0, `fifo_level` = 0, `ovf` = 0, `proto_err` = 0.
- All accumulators, sample counters, frame counters, pointers and the result register = 0.

Latency:
- Completing strobe sampled at edge k: result register loaded at k, FIFO written at k+1, `m_valid` high after k+1 when the FIFO was empty.
- Equivalently, 2 cycles from the strobe cycle to `m_valid`.

Throughput:
- Accepts a strobe every cycle.
- Upstream delivers at most one strobe per 76 cycles.

Handshake:
- `m_data` and `m_valid` are stable while `m_valid` && !`m_ready`.

Reset mid-operation:
- All state clears immediately and in-flight results are lost.

## Structure
- A package `ad7946_pkg` holds:
  - the `m_data` field positions;
  - SUM_W = 22, FRM_W = 7, SAMPLE_W = 14;
  - a packed struct `dec_word_t {chan, frm, pad, sum}`.
- Sub-module `sync_fifo_fwft` (WIDTH, DEPTH) provides the FIFO: full/empty, level, same-cycle push/pop.
- Top level holds the per-channel accumulator logic as a 2-entry array indexed by channel, plus the result register and error flags.

## Test plan
1. LOG2_DECIM = 2. Ch0 samples 100, 200, 300, 400 → one word `0x000003E8` (chan 0, frm 0), `m_valid` 2 cycles after the 4th strobe. The next ch0 frame carries frm 1.
2. Interleaved ch0/ch1 at the upstream cadence, ch1 = 16383 ×4 → ch1 word `0x8000FFFC`. With LOG2_DECIM = 8 and all 16383 → sum `0x3FFF00`, no wrap.
3. `m_ready` = 0, fill to FIFO_DEPTH, one more completion → `ovf` = 1, word dropped. After draining, frm values show the gap. `clear_err` → `ovf` = 0.
4. `ch0_dv` = `ch1_dv` = 1 in one cycle → only the ch0 count advances, `proto_err` = 1. `clear_err` in the same cycle as a new violation → stays 1.
5. `enable` dropped after 2 of 4 samples, then re-enabled, then 4 samples of 10 → word sum 40, frm 0.
6. `resetn` low mid-frame with a full FIFO → `m_valid`, `fifo_level` and flags are 0 asynchronously. The first post-reset frame is frm 0.
